// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared encodings and width helper for the multi-account ATM controller
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AUTH   = 3'd1,
        ST_MENU   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4,
        ST_LOCKED = 3'd5
    } atm_state_t;

    localparam logic [2:0] OP_INQUIRY  = 3'd0;
    localparam logic [2:0] OP_WITHDRAW = 3'd1;
    localparam logic [2:0] OP_DEPOSIT  = 3'd2;
    localparam logic [2:0] OP_CHG_PIN  = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;
    localparam logic [2:0] OP_EXIT     = 3'd5;

    localparam logic [3:0] ERR_OK       = 4'd0;
    localparam logic [3:0] ERR_BAD_ACC  = 4'd1;
    localparam logic [3:0] ERR_BAD_PIN  = 4'd2;
    localparam logic [3:0] ERR_LOCKED   = 4'd3;
    localparam logic [3:0] ERR_INSUFF   = 4'd4;
    localparam logic [3:0] ERR_LIMIT    = 4'd5;
    localparam logic [3:0] ERR_OVERFLOW = 4'd6;
    localparam logic [3:0] ERR_BAD_REQ  = 4'd7;
    localparam logic [3:0] ERR_TIMEOUT  = 4'd8;

    // ceil(log2(n)) with a floor of one bit, so a single-entry store still has an index
    function automatic int calc_acc_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/atm_acct_store.sv
// rtl/atm_acct_store.sv - per-account balance, PIN, fail count and lock flag register file
module atm_acct_store
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 16,
    parameter int ACC_W        = 4,
    parameter int BAL_W        = 16,
    parameter int PIN_W        = 16,
    parameter int FAIL_W       = 2,
    parameter int INIT_BAL     = 1000,
    parameter int DEFAULT_PIN  = 1234
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACC_W-1:0]  src_idx,
    input  logic [ACC_W-1:0]  dst_idx,
    output logic [BAL_W-1:0]  src_bal,
    output logic [PIN_W-1:0]  src_pin,
    output logic [FAIL_W-1:0] src_fails,
    output logic              src_locked,
    output logic [BAL_W-1:0]  dst_bal,
    input  logic              bal_we,
    input  logic [BAL_W-1:0]  bal_wdata,
    input  logic              pin_we,
    input  logic [PIN_W-1:0]  pin_wdata,
    input  logic              fails_we,
    input  logic [FAIL_W-1:0] fails_wdata,
    input  logic              lock_we,
    input  logic              dst_we,
    input  logic [BAL_W-1:0]  dst_wdata
);

    localparam logic [ACC_W:0] NUM_ACC_L = (ACC_W+1)'(NUM_ACCOUNTS);

    logic [BAL_W-1:0]  bal_q   [NUM_ACCOUNTS];
    logic [PIN_W-1:0]  pin_q   [NUM_ACCOUNTS];
    logic [FAIL_W-1:0] fails_q [NUM_ACCOUNTS];
    logic              lock_q  [NUM_ACCOUNTS];

    logic src_ok;
    logic dst_ok;

    assign src_ok = {1'b0, src_idx} < NUM_ACC_L;
    assign dst_ok = {1'b0, dst_idx} < NUM_ACC_L;

    // Out-of-range indices read as an empty, unlocked account
    assign src_bal    = src_ok ? bal_q[src_idx]   : '0;
    assign src_pin    = src_ok ? pin_q[src_idx]   : '0;
    assign src_fails  = src_ok ? fails_q[src_idx] : '0;
    assign src_locked = src_ok ? lock_q[src_idx]  : 1'b0;
    assign dst_bal    = dst_ok ? bal_q[dst_idx]   : '0;

    // Storage update; source and destination never alias because transfers to self are rejected upstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal_q[i]   <= BAL_W'(INIT_BAL);
                pin_q[i]   <= PIN_W'(DEFAULT_PIN);
                fails_q[i] <= '0;
                lock_q[i]  <= 1'b0;
            end
        end else begin
            if (bal_we && src_ok)   bal_q[src_idx]   <= bal_wdata;
            if (pin_we && src_ok)   pin_q[src_idx]   <= pin_wdata;
            if (fails_we && src_ok) fails_q[src_idx] <= fails_wdata;
            if (lock_we && src_ok)  lock_q[src_idx]  <= 1'b1;
            if (dst_we && dst_ok)   bal_q[dst_idx]   <= dst_wdata;
        end
    end

endmodule

// File: rtl/atm_multi_ctrl.sv
// rtl/atm_multi_ctrl.sv - ATM session FSM over an account store; optional idle timeout via ATM_TIMEOUT_EN
module atm_multi_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 16,
    parameter int BAL_W        = 16,
    parameter int PIN_W        = 16,
    parameter int INIT_BAL     = 1000,
    parameter int DEFAULT_PIN  = 1234,
    parameter int MAX_TRIES    = 3,
    parameter int WD_LIMIT     = 500,
    parameter int TIMEOUT_CYC  = 64,
    localparam int ACC_W       = calc_acc_w(NUM_ACCOUNTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_in,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             pin_valid,
    input  logic [2:0]       operation,
    input  logic             op_valid,
    input  logic [BAL_W-1:0] amount,
    input  logic [PIN_W-1:0] new_pin,
    input  logic [ACC_W-1:0] dest_acc,
    output logic [BAL_W-1:0] balance,
    output logic             success,
    output logic [3:0]       err,
    output logic [2:0]       state
);

    localparam int FAIL_W = calc_acc_w(MAX_TRIES + 1);
    localparam logic [ACC_W:0]  NUM_ACC_L  = (ACC_W+1)'(NUM_ACCOUNTS);
    localparam logic [BAL_W:0]  WD_LIMIT_L = (BAL_W+1)'(WD_LIMIT);
    localparam logic [FAIL_W-1:0] MAX_TRIES_L = FAIL_W'(MAX_TRIES);

    atm_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [BAL_W-1:0] amt_q, amt_d;
    logic [PIN_W-1:0] npin_q, npin_d;
    logic [ACC_W-1:0] dst_q, dst_d;
    logic [BAL_W-1:0] wd_q, wd_d;
    logic             auth_q, auth_d;
    logic [3:0]       err_q, err_d;
    logic             success_q, success_d;
    logic [BAL_W-1:0] balance_q, balance_d;

    logic [ACC_W-1:0]  rd_idx;
    logic [BAL_W-1:0]  src_bal, dst_bal;
    logic [PIN_W-1:0]  src_pin;
    logic [FAIL_W-1:0] src_fails, fails_inc;
    logic              src_locked;
    logic              bal_we, pin_we, fails_we, lock_we, dst_we;
    logic [BAL_W-1:0]  bal_wdata, dst_wdata;
    logic [FAIL_W-1:0] fails_wdata;

    logic             acc_ok, dst_ok, is_wd, is_xfer, is_debit;
    logic [BAL_W:0]   dep_sum, xfer_sum, wd_sum;
    logic             tmo_hit;

    // In IDLE the store is probed with the raw card account; afterwards with the latched one
    assign rd_idx    = (state_q == ST_IDLE) ? acc_num : acc_q;
    assign acc_ok    = {1'b0, acc_num} < NUM_ACC_L;
    assign dst_ok    = {1'b0, dst_q} < NUM_ACC_L;
    assign is_wd     = (op_q == OP_WITHDRAW);
    assign is_xfer   = (op_q == OP_TRANSFER);
    assign is_debit  = is_wd | is_xfer;
    assign dep_sum   = {1'b0, src_bal} + {1'b0, amt_q};
    assign xfer_sum  = {1'b0, dst_bal} + {1'b0, amt_q};
    assign wd_sum    = {1'b0, wd_q} + {1'b0, amt_q};
    assign fails_inc = src_fails + 1'b1;

`ifdef ATM_TIMEOUT_EN
    localparam int TMO_W = calc_acc_w(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign tmo_d   = ((state_q == ST_AUTH || state_q == ST_MENU) && state_d == state_q
                      && !pin_valid && !op_valid) ? tmo_q + 1'b1 : '0;

    // Idle-cycle counter; restarts on any state change or user input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYC != 0);
    assign tmo_hit    = 1'b0;
`endif

    atm_acct_store #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .ACC_W        (ACC_W),
        .BAL_W        (BAL_W),
        .PIN_W        (PIN_W),
        .FAIL_W       (FAIL_W),
        .INIT_BAL     (INIT_BAL),
        .DEFAULT_PIN  (DEFAULT_PIN)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .src_idx     (rd_idx),
        .dst_idx     (dst_q),
        .src_bal     (src_bal),
        .src_pin     (src_pin),
        .src_fails   (src_fails),
        .src_locked  (src_locked),
        .dst_bal     (dst_bal),
        .bal_we      (bal_we),
        .bal_wdata   (bal_wdata),
        .pin_we      (pin_we),
        .pin_wdata   (npin_q),
        .fails_we    (fails_we),
        .fails_wdata (fails_wdata),
        .lock_we     (lock_we),
        .dst_we      (dst_we),
        .dst_wdata   (dst_wdata)
    );

    // Session registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            op_q      <= '0;
            amt_q     <= '0;
            npin_q    <= '0;
            dst_q     <= '0;
            wd_q      <= '0;
            auth_q    <= 1'b0;
            err_q     <= ERR_OK;
            success_q <= 1'b0;
            balance_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            amt_q     <= amt_d;
            npin_q    <= npin_d;
            dst_q     <= dst_d;
            wd_q      <= wd_d;
            auth_q    <= auth_d;
            err_q     <= err_d;
            success_q <= success_d;
            balance_q <= balance_d;
        end
    end

    // Next-state, result codes and store write strobes
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        amt_d       = amt_q;
        npin_d      = npin_q;
        dst_d       = dst_q;
        wd_d        = wd_q;
        auth_d      = auth_q;
        err_d       = err_q;
        success_d   = 1'b0;
        bal_we      = 1'b0;
        bal_wdata   = src_bal;
        pin_we      = 1'b0;
        fails_we    = 1'b0;
        fails_wdata = src_fails;
        lock_we     = 1'b0;
        dst_we      = 1'b0;
        dst_wdata   = dst_bal;

        if (state_q != ST_IDLE && !card_in) begin
            state_d = ST_IDLE;
            err_d   = ERR_OK;
            auth_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    err_d  = ERR_OK;
                    auth_d = 1'b0;
                    if (card_in) begin
                        if (!acc_ok) begin
                            state_d = ST_DONE;
                            err_d   = ERR_BAD_ACC;
                        end else if (src_locked) begin
                            state_d = ST_LOCKED;
                            err_d   = ERR_LOCKED;
                        end else begin
                            acc_d   = acc_num;
                            wd_d    = '0;
                            state_d = ST_AUTH;
                        end
                    end
                end
                ST_AUTH: begin
                    err_d = ERR_OK;
                    if (pin_valid) begin
                        fails_we = 1'b1;
                        if (pin == src_pin) begin
                            fails_wdata = '0;
                            auth_d      = 1'b1;
                            state_d     = ST_MENU;
                        end else begin
                            fails_wdata = fails_inc;
                            err_d       = ERR_BAD_PIN;
                            if (fails_inc >= MAX_TRIES_L) begin
                                lock_we = 1'b1;
                                state_d = ST_LOCKED;
                                err_d   = ERR_LOCKED;
                            end
                        end
                    end else if (tmo_hit) begin
                        state_d = ST_IDLE;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                ST_MENU: begin
                    if (op_valid) begin
                        if (operation == OP_EXIT) begin
                            state_d   = ST_IDLE;
                            success_d = 1'b1;
                            err_d     = ERR_OK;
                            auth_d    = 1'b0;
                        end else begin
                            op_d    = operation;
                            amt_d   = amount;
                            npin_d  = new_pin;
                            dst_d   = dest_acc;
                            state_d = ST_EXEC;
                        end
                    end else if (tmo_hit) begin
                        state_d = ST_IDLE;
                        err_d   = ERR_TIMEOUT;
                        auth_d  = 1'b0;
                    end
                end
                ST_EXEC: begin
                    state_d = ST_DONE;
                    if (op_q > OP_EXIT) begin
                        err_d = ERR_BAD_REQ;
                    end else if (is_debit && amt_q == '0) begin
                        err_d = ERR_BAD_REQ;
                    end else if (is_xfer && (dst_q == acc_q || !dst_ok)) begin
                        err_d = ERR_BAD_ACC;
                    end else if (is_debit && amt_q > src_bal) begin
                        err_d = ERR_INSUFF;
                    end else if (is_debit && wd_sum > WD_LIMIT_L) begin
                        err_d = ERR_LIMIT;
                    end else if (op_q == OP_DEPOSIT && dep_sum[BAL_W]) begin
                        err_d = ERR_OVERFLOW;
                    end else if (is_xfer && xfer_sum[BAL_W]) begin
                        err_d = ERR_OVERFLOW;
                    end else begin
                        err_d     = ERR_OK;
                        success_d = 1'b1;
                        case (op_q)
                            OP_WITHDRAW: begin
                                bal_we    = 1'b1;
                                bal_wdata = src_bal - amt_q;
                                wd_d      = wd_sum[BAL_W-1:0];
                            end
                            OP_DEPOSIT: begin
                                bal_we    = 1'b1;
                                bal_wdata = dep_sum[BAL_W-1:0];
                            end
                            OP_CHG_PIN: begin
                                pin_we = 1'b1;
                            end
                            OP_TRANSFER: begin
                                bal_we    = 1'b1;
                                bal_wdata = src_bal - amt_q;
                                dst_we    = 1'b1;
                                dst_wdata = xfer_sum[BAL_W-1:0];
                                wd_d      = wd_sum[BAL_W-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: begin
                    if (auth_q) begin
                        state_d = ST_MENU;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = ERR_OK;
                    end
                end
                ST_LOCKED: ;
                default: begin
                    state_d = ST_IDLE;
                    err_d   = ERR_OK;
                    auth_d  = 1'b0;
                end
            endcase
        end

        // Displayed balance tracks the session account, including this cycle's own write
        balance_d = '0;
        if (state_d == ST_AUTH || state_d == ST_MENU || state_d == ST_EXEC
            || (state_d == ST_DONE && auth_d)) begin
            balance_d = bal_we ? bal_wdata : src_bal;
        end
    end

    assign balance = balance_q;
    assign success = success_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_atm_multi_ctrl.sv
// tb/tb_atm_multi_ctrl.sv - directed self-checking bench for atm_multi_ctrl
module tb_atm_multi_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_in;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        pin_valid;
    logic [2:0]  operation;
    logic        op_valid;
    logic [15:0] amount;
    logic [15:0] new_pin;
    logic [3:0]  dest_acc;
    logic [15:0] balance;
    logic        success;
    logic [3:0]  err;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int s_r, e_r, b_r;

    atm_multi_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .card_in   (card_in),
        .acc_num   (acc_num),
        .pin       (pin),
        .pin_valid (pin_valid),
        .operation (operation),
        .op_valid  (op_valid),
        .amount    (amount),
        .new_pin   (new_pin),
        .dest_acc  (dest_acc),
        .balance   (balance),
        .success   (success),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic login(input logic [3:0] acc, input logic [15:0] pin_v);
        card_in = 1'b1;
        acc_num = acc;
        tick();
        pin       = pin_v;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
    endtask

    task automatic logout();
        card_in = 1'b0;
        tick();
    endtask

    task automatic do_op(input logic [2:0] op, input logic [15:0] amt, input logic [3:0] dst,
                         output int s_o, output int e_o, output int b_o);
        operation = op;
        amount    = amt;
        dest_acc  = dst;
        op_valid  = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        s_o = success;
        e_o = err;
        b_o = balance;
        tick();
    endtask

    initial begin
        rst = 1'b1; card_in = 1'b0; acc_num = '0; pin = '0; pin_valid = 1'b0;
        operation = '0; op_valid = 1'b0; amount = '0; new_pin = '0; dest_acc = '0;
        tick();
        tick();
        chk("rst_balance", balance, 0);
        chk("rst_success", success, 0);
        chk("rst_err", err, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;
        tick();

        // withdraw 90 on acc 1 with exact latency
        card_in = 1'b1; acc_num = 4'd1;
        tick();
        chk("auth_state", state, 1);
        chk("auth_balance", balance, 1000);
        pin = 16'd1234; pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
        chk("menu_state", state, 2);
        operation = 3'd1; amount = 16'd90; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("exec_state", state, 3);
        chk("exec_success", success, 0);
        tick();
        chk("done_state", state, 4);
        chk("wd90_success", success, 1);
        chk("wd90_balance", balance, 910);
        chk("wd90_err", err, 0);
        tick();
        chk("wd90_menu", state, 2);
        chk("wd90_pulse_end", success, 0);
        logout();
        chk("logout_state", state, 0);
        chk("logout_balance", balance, 0);

        // wrong PIN lockout on acc 2
        card_in = 1'b1; acc_num = 4'd2;
        tick();
        for (int i = 0; i < 3; i++) begin
            pin = 16'd1111; pin_valid = 1'b1;
            tick();
            pin_valid = 1'b0;
            if (i < 2) begin
                chk("badpin_err", err, 2);
                chk("badpin_state", state, 1);
                tick();
                chk("badpin_pulse_end", err, 0);
            end else begin
                chk("lock_state", state, 5);
            end
        end
        logout();
        chk("lock_exit_state", state, 0);
        chk("lock_exit_err", err, 0);
        card_in = 1'b1; acc_num = 4'd2;
        tick();
        chk("relock_state", state, 5);
        chk("relock_err", err, 3);
        chk("relock_balance", balance, 0);
        logout();

        // session withdrawal limit on acc 5
        login(4'd5, 16'd1234);
        do_op(3'd1, 16'd400, 4'd0, s_r, e_r, b_r);
        chk("wd400_success", s_r, 1);
        chk("wd400_balance", b_r, 600);
        do_op(3'd1, 16'd200, 4'd0, s_r, e_r, b_r);
        chk("limit_err", e_r, 5);
        chk("limit_success", s_r, 0);
        chk("limit_balance", b_r, 600);
        chk("limit_err_held", err, 5);
        chk("limit_menu", state, 2);
        logout();
        login(4'd5, 16'd1234);
        do_op(3'd1, 16'd200, 4'd0, s_r, e_r, b_r);
        chk("newsess_err", e_r, 0);
        chk("newsess_balance", b_r, 400);
        logout();

        // transfers and error priorities on acc 3 / acc 4
        login(4'd3, 16'd1234);
        do_op(3'd4, 16'd300, 4'd3, s_r, e_r, b_r);
        chk("xfer_self_err", e_r, 1);
        chk("xfer_self_balance", b_r, 1000);
        do_op(3'd4, 16'd300, 4'd4, s_r, e_r, b_r);
        chk("xfer_success", s_r, 1);
        chk("xfer_src_balance", b_r, 700);
        do_op(3'd1, 16'd0, 4'd0, s_r, e_r, b_r);
        chk("wd_zero_err", e_r, 7);
        do_op(3'd6, 16'd10, 4'd0, s_r, e_r, b_r);
        chk("bad_op_err", e_r, 7);
        do_op(3'd1, 16'd701, 4'd0, s_r, e_r, b_r);
        chk("insuff_err", e_r, 4);
        chk("insuff_balance", b_r, 700);
        logout();
        login(4'd4, 16'd1234);
        chk("xfer_dst_balance", balance, 1300);
        do_op(3'd2, 16'd65000, 4'd0, s_r, e_r, b_r);
        chk("ovf_err", e_r, 6);
        chk("ovf_balance", b_r, 1300);
        do_op(3'd0, 16'd0, 4'd0, s_r, e_r, b_r);
        chk("inquiry_err", e_r, 0);
        chk("inquiry_success", s_r, 1);
        operation = 3'd5; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        chk("exit_state", state, 0);
        chk("exit_success", success, 1);
        card_in = 1'b0;
        tick();

        // PIN change on acc 7 then login with new PIN
        login(4'd7, 16'd1234);
        new_pin = 16'd4321;
        do_op(3'd3, 16'd0, 4'd0, s_r, e_r, b_r);
        chk("chgpin_success", s_r, 1);
        logout();
        login(4'd7, 16'd4321);
        chk("newpin_state", state, 2);
        logout();

        // abort during EXEC of deposit 50 on acc 6
        login(4'd6, 16'd1234);
        operation = 3'd2; amount = 16'd50; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        card_in  = 1'b0;
        tick();
        chk("abort_state", state, 0);
        chk("abort_success", success, 0);
        login(4'd6, 16'd1234);
        chk("abort_balance", balance, 1000);

`ifdef ATM_TIMEOUT_EN
        for (int i = 0; i < 63; i++) tick();
        chk("tmo_before", state, 2);
        tick();
        chk("tmo_state", state, 0);
        chk("tmo_err", err, 8);
        tick();
        chk("tmo_err_clear", err, 0);
        card_in = 1'b0;
        tick();
`else
        for (int i = 0; i < 80; i++) tick();
        chk("no_tmo_state", state, 2);
        logout();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
